// File: rtl/seg_scan_disp.sv
// rtl/seg_scan_disp.sv - two-digit multiplexed 7-segment driver for a 4-bit async count
// Optional macro LZ_BLANK_EN: blank the tens digit when it is zero.
module seg_scan_disp #(
  parameter int SCAN_DIV   = 50,
  parameter int BLANK_CYC  = 2,
  parameter int STABLE_CYC = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cnt_in,
  output logic [6:0] seg,
  output logic [1:0] dig_sel,
  output logic       chg
);

  localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int SW   = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] LIT_LEN  = CW'(SCAN_DIV);
  localparam logic [CW-1:0] BLK_LEN  = CW'(BLANK_CYC);

  typedef enum logic [1:0] {ONES, BLANK_A, TENS, BLANK_B} state_t;

  logic [3:0]    sync1_q, sync2_q, cand_q, cand_d, disp_q, disp_d;
  logic [SW-1:0] stab_q, stab_d;
  logic          chg_q, chg_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cur_len;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    dig_q, dig_d;
  logic          tens;
  logic [3:0]    ones_v;

  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'd0: dec7 = 7'h3F;
      4'd1: dec7 = 7'h06;
      4'd2: dec7 = 7'h5B;
      4'd3: dec7 = 7'h4F;
      4'd4: dec7 = 7'h66;
      4'd5: dec7 = 7'h6D;
      4'd6: dec7 = 7'h7D;
      4'd7: dec7 = 7'h07;
      4'd8: dec7 = 7'h7F;
      4'd9: dec7 = 7'h6F;
      default: dec7 = 7'h00;
    endcase
  endfunction

  // A candidate must survive STABLE_CYC consecutive samples before it is displayed.
  always_comb begin
    cand_d = cand_q;
    stab_d = stab_q;
    disp_d = disp_q;
    chg_d  = 1'b0;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      stab_d = '0;
    end else if (stab_q != STAB_MAX) begin
      stab_d = stab_q + 1'b1;
    end
    if (stab_q == STAB_MAX && cand_q != disp_q) begin
      disp_d = cand_q;
      chg_d  = 1'b1;
    end
  end

  // Counter runs 1..len within a state; reset value 0 adds one edge to the first blank.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    cur_len = (state_q == ONES || state_q == TENS) ? LIT_LEN : BLK_LEN;
    if (cnt_q == cur_len) begin
      cnt_d = CW'(1);
      case (state_q)
        ONES:    state_d = BLANK_A;
        BLANK_A: state_d = TENS;
        TENS:    state_d = BLANK_B;
        default: state_d = ONES;
      endcase
    end
  end

  assign tens   = (disp_q >= 4'd10);
  assign ones_v = tens ? (disp_q - 4'd10) : disp_q;

  // Outputs follow state_d so seg and dig_sel switch on the same edge as the state.
  always_comb begin
    seg_d = 7'h00;
    dig_d = 2'b00;
    case (state_d)
      ONES: begin
        seg_d = dec7(ones_v);
        dig_d = 2'b01;
      end
      TENS: begin
        dig_d = 2'b10;
`ifdef LZ_BLANK_EN
        seg_d = tens ? 7'h06 : 7'h00;
`else
        seg_d = dec7({3'b000, tens});
`endif
      end
      default: begin
        seg_d = 7'h00;
        dig_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      stab_q  <= '0;
      disp_q  <= '0;
      chg_q   <= 1'b0;
      state_q <= BLANK_B;
      cnt_q   <= '0;
      seg_q   <= '0;
      dig_q   <= '0;
    end else begin
      sync1_q <= cnt_in;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      stab_q  <= stab_d;
      disp_q  <= disp_d;
      chg_q   <= chg_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
    end
  end

  assign seg     = seg_q;
  assign dig_sel = dig_q;
  assign chg     = chg_q;

endmodule

// File: doc/seg_scan_disp.md
SEG_SCAN_DISP -- requirements
Module: seg_scan_disp

Interface
REQ-001 Parameter SCAN_DIV, default 50: clk cycles each digit is lit; legal range >=2.
REQ-002 Parameter BLANK_CYC, default 2: all-off cycles between digits; legal range >=1.
REQ-003 Parameter STABLE_CYC, default 3: cycles a synchronized input must hold before it is accepted; legal range >=1.
REQ-004 clk  input  1  sole clock; all state rising-edge triggered.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 cnt_in  input  [3:0]  binary count 0..15 from the upstream 4-bit counter; not related to clk, may change at any time.
REQ-007 seg  output  [6:0]  registered segment drive, active-high, seg[0]=a .. seg[6]=g.
REQ-008 dig_sel  output  [1:0]  registered digit enable, one-hot or zero; bit0=ones digit, bit1=tens digit.
REQ-009 chg  output  1  registered one-cycle pulse when a new display value is accepted.

Function
REQ-010 cnt_in SHALL pass through a 2-flop synchronizer (sync value = cnt_in delayed 2 clk edges).
REQ-011 Filter: candidate register cand; if sync != cand then cand<=sync and stab_cnt<=0; otherwise stab_cnt SHALL increment, saturating at STABLE_CYC-1.
REQ-012 When stab_cnt==STABLE_CYC-1 and cand != disp_val, disp_val<=cand and chg SHALL be 1 for exactly the next cycle; in all other cycles chg=0.
REQ-013 An equal value re-accepted SHALL NOT pulse chg; a value held shorter than STABLE_CYC cycles SHALL NOT reach disp_val.
REQ-014 Decimal split: tens = (disp_val>=10) ? 1 : 0; ones = disp_val - 10*tens; values 10..15 SHALL display as 10..15.
REQ-015 Decode: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F (hex, seg[6:0]).
REQ-016 Scan FSM states ONES, BLANK_A, TENS, BLANK_B; cycle ONES->BLANK_A->TENS->BLANK_B->ONES.
REQ-017 ONES and TENS each last exactly SCAN_DIV cycles; BLANK_A and BLANK_B each last exactly BLANK_CYC cycles; one shared down/up counter times every state.
REQ-018 ONES: dig_sel=01, seg=decode(ones); TENS: dig_sel=10, seg=decode(tens); blank states: dig_sel=00, seg=00.
REQ-019 seg and dig_sel SHALL change on the same clk edge; dig_sel SHALL never be 11.
REQ-020 seg SHALL track disp_val within a lit state: a disp_val update mid-digit is shown from the following cycle.
REQ-021 Full scan period = 2*SCAN_DIV + 2*BLANK_CYC cycles (104 at defaults).

Reset
REQ-022 While rst=1: seg=00, dig_sel=00, chg=0, disp_val=0, cand=0, stab_cnt=0, synchronizer flops=0, FSM=BLANK_B, state counter=0, asynchronously.
REQ-023 After rst falls, first ONES entry SHALL occur BLANK_CYC cycles after the first rising clk edge.
REQ-024 Reset asserted mid-scan or mid-filter SHALL abort immediately; no chg pulse on reset release.

Configuration
REQ-025 Macro LZ_BLANK_EN: when defined, TENS state with tens==0 SHALL drive seg=00 while keeping dig_sel=10 and its timing unchanged.
REQ-026 Without LZ_BLANK_EN, TENS with tens==0 SHALL drive seg=3F.

Verification
REQ-027 Reset, cnt_in=0: dig_sel 00 for 2 cycles, then 01/seg=3F for 50 cycles, 00 for 2, 10 for 50 (seg=3F without LZ_BLANK_EN, 00 with).
REQ-028 cnt_in 0->7 held: chg pulses once 2+STABLE_CYC (=5) cycles after change; ONES shows 07, TENS shows 3F/00 per macro.
REQ-029 cnt_in=13: ONES seg=4F, TENS seg=06; cnt_in 15->0 wrap: ONES seg=3F, chg pulses once.
REQ-030 cnt_in glitch 3->9->3, 9 held 2 cycles (STABLE_CYC=3): disp_val stays 3, chg never pulses.
REQ-031 rst asserted during TENS: outputs 00/00 immediately, disp_val=0; after release first lit digit ONES after BLANK_CYC cycles.
REQ-032 Free-running check over 1000 cycles: dig_sel never 11, period exactly 104 cycles, every lit interval exactly 50 cycles.
